// File: rtl/video_timing_scaler.sv
// Raster timing generator for a parameterised video mode. It adds integer pixel
// replication, sync polarity selection and a built-in test pattern.
module video_timing_scaler #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int SCALE_X   = 1,
    parameter int SCALE_Y   = 1,
    parameter int CNT_W     = 12
) (
    input  logic             clk_pixel,
    input  logic             rst,
    input  logic             test_picture,
    input  logic [7:0]       red,
    input  logic [7:0]       green,
    input  logic [7:0]       blue,
    output logic             fetch_next,
    output logic             next_line,
    output logic             repeat_line,
    output logic             next_field,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             vga_blank,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] SX_MASK    = CNT_W'(SCALE_X - 1);
    localparam logic [CNT_W-1:0] SY_MASK    = CNT_W'(SCALE_Y - 1);
    localparam logic             HS_ON      = (HSYNC_POL != 0);
    localparam logic             VS_ON      = (VSYNC_POL != 0);

    generate
        if (!(SCALE_X == 1 || SCALE_X == 2 || SCALE_X == 4) ||
            !(SCALE_Y == 1 || SCALE_Y == 2 || SCALE_Y == 4)) begin : g_bad_scale
            $error("video_timing_scaler: SCALE_X/SCALE_Y must be 1, 2 or 4");
        end
        if ((H_ACTIVE % SCALE_X) != 0 || (V_ACTIVE % SCALE_Y) != 0) begin : g_bad_active
            $error("video_timing_scaler: active size must be a multiple of the scale");
        end
        if (CNT_W < 8 || H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
            $error("video_timing_scaler: CNT_W too small for the timing totals");
        end
    endgenerate

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + CNT_W'(1);
        end else begin
            h <= h + CNT_W'(1);
        end
    end

    logic active;
    logic h_sync_win;
    logic v_sync_win;
    logic line_end;
    logic last_sub_line;

    assign active        = (h < H_ACT) && (v < V_ACT);
    assign h_sync_win    = (h >= HS_START) && (h < HS_END);
    assign v_sync_win    = (v >= VS_START) && (v < VS_END);
    assign line_end      = !rst && active && (h == H_ACT_LAST);
    assign last_sub_line = ((v & SY_MASK) == SY_MASK);

    // Source handshake: the source presents a pixel and holds it; fetch_next high
    // in a cycle means the pixel is consumed at the following clock edge and the
    // source must present its next one. Line/field pulses reposition the source
    // at the same edge and take priority over the fetch advance.
    assign fetch_next  = !rst && active && ((h & SX_MASK) == SX_MASK);
    assign next_line   = line_end && last_sub_line && (v != V_ACT_LAST);
    assign repeat_line = line_end && !last_sub_line && (v != V_ACT_LAST);
    assign next_field  = !rst && (h == H_LAST) && (v == V_LAST);

    assign hcount = h;
    assign vcount = v;

    // One register stage keeps colour, syncs and blank aligned with each other.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            vga_r     <= 8'd0;
            vga_g     <= 8'd0;
            vga_b     <= 8'd0;
            vga_blank <= 1'b1;
            vga_hsync <= ~HS_ON;
            vga_vsync <= ~VS_ON;
        end else begin
            vga_blank <= !active;
            vga_hsync <= h_sync_win ? HS_ON : ~HS_ON;
            vga_vsync <= v_sync_win ? VS_ON : ~VS_ON;
            if (!active) begin
                vga_r <= 8'd0;
                vga_g <= 8'd0;
                vga_b <= 8'd0;
            end else if (test_picture) begin
                vga_r <= h[7:0];
                vga_g <= v[7:0];
                vga_b <= h[7:0] ^ v[7:0];
            end else begin
                vga_r <= red;
                vga_g <= green;
                vga_b <= blue;
            end
        end
    end
endmodule

// File: tb/tb_video_timing_scaler.sv
// Bench for video_timing_scaler: one unscaled active-low instance and one 2x2 scaled
// active-high instance on a 14x7 raster, checked against a reference raster model.
module tb_video_timing_scaler;
    localparam int CNT_W = 12;
    localparam int EXP_W = 53;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic test_picture = 1'b0;
    logic [7:0] red_a = 8'd0, green_a = 8'd0, blue_a = 8'd0;
    logic [7:0] red_b = 8'd0, green_b = 8'd0, blue_b = 8'd0;

    logic fetch_next_a, next_line_a, repeat_line_a, next_field_a;
    logic fetch_next_b, next_line_b, repeat_line_b, next_field_b;
    logic [7:0] vga_r_a, vga_g_a, vga_b_a, vga_r_b, vga_g_b, vga_b_b;
    logic vga_hsync_a, vga_vsync_a, vga_blank_a, vga_hsync_b, vga_vsync_b, vga_blank_b;
    logic [CNT_W-1:0] hcount_a, vcount_a, hcount_b, vcount_b;

    video_timing_scaler #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(0), .VSYNC_POL(0), .SCALE_X(1), .SCALE_Y(1), .CNT_W(CNT_W)
    ) u_dut_a (
        .clk_pixel(clk), .rst(rst), .test_picture(test_picture),
        .red(red_a), .green(green_a), .blue(blue_a),
        .fetch_next(fetch_next_a), .next_line(next_line_a),
        .repeat_line(repeat_line_a), .next_field(next_field_a),
        .vga_r(vga_r_a), .vga_g(vga_g_a), .vga_b(vga_b_a),
        .vga_hsync(vga_hsync_a), .vga_vsync(vga_vsync_a), .vga_blank(vga_blank_a),
        .hcount(hcount_a), .vcount(vcount_a)
    );

    video_timing_scaler #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .SCALE_X(2), .SCALE_Y(2), .CNT_W(CNT_W)
    ) u_dut_b (
        .clk_pixel(clk), .rst(rst), .test_picture(test_picture),
        .red(red_b), .green(green_b), .blue(blue_b),
        .fetch_next(fetch_next_b), .next_line(next_line_b),
        .repeat_line(repeat_line_b), .next_field(next_field_b),
        .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
        .vga_hsync(vga_hsync_b), .vga_vsync(vga_vsync_b), .vga_blank(vga_blank_b),
        .hcount(hcount_b), .vcount(vcount_b)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [EXP_W-1:0] exp_q[$];

    // Reference raster position of the current cycle and the framebuffer pointer of instance b
    int mh = 0, mv = 0;
    int src_px = 0, src_ly = 0;

    logic mon_en = 1'b0;
    int cyc = 0, nf_cnt = 0, nf_last = -1, nf_prev = -1;
    int fa_cnt = 0, fb_cnt = 0, nla_cnt = 0, rla_cnt = 0, nlb_cnt = 0, rlb_cnt = 0;
    logic seen_fetch_b = 1'b0, seen_nl_b = 1'b0, seen_rl_b = 1'b0, seen_nf_b = 1'b0;

    logic m_act, m_le;
    logic [3:0] exp_hs_a, exp_hs_b, got_hs_a, got_hs_b;
    logic [EXP_W-1:0] e_mon;

    // Monitor: combinational outputs against the model, registered outputs from the queue
    always @(negedge clk) begin
        if (mon_en) begin
            m_act = (mh < 8) && (mv < 4);
            m_le = !rst && m_act && (mh == 7);
            exp_hs_a = {!rst && m_act, m_le && (mv != 3), 1'b0, !rst && (mh == 13) && (mv == 6)};
            exp_hs_b = {!rst && m_act && (mh % 2 == 1), m_le && (mv == 1),
                        m_le && (mv == 0 || mv == 2), !rst && (mh == 13) && (mv == 6)};
            got_hs_a = {fetch_next_a, next_line_a, repeat_line_a, next_field_a};
            got_hs_b = {fetch_next_b, next_line_b, repeat_line_b, next_field_b};
            n_checks++;
            if (got_hs_a !== exp_hs_a) begin
                n_fail++;
                $display("FAIL handshake_a h=%0d v=%0d got %b want %b", mh, mv, got_hs_a, exp_hs_a);
            end
            n_checks++;
            if (got_hs_b !== exp_hs_b) begin
                n_fail++;
                $display("FAIL handshake_b h=%0d v=%0d got %b want %b", mh, mv, got_hs_b, exp_hs_b);
            end
            n_checks++;
            if ({hcount_a, vcount_a, hcount_b, vcount_b} !==
                {CNT_W'(mh), CNT_W'(mv), CNT_W'(mh), CNT_W'(mv)}) begin
                n_fail++;
                $display("FAIL counters got a=%0d,%0d b=%0d,%0d want %0d,%0d",
                         hcount_a, vcount_a, hcount_b, vcount_b, mh, mv);
            end
            {seen_fetch_b, seen_nl_b, seen_rl_b, seen_nf_b} = got_hs_b;
            if (fetch_next_a === 1'b1) fa_cnt++;
            if (fetch_next_b === 1'b1) fb_cnt++;
            if (next_line_a === 1'b1) nla_cnt++;
            if (repeat_line_a === 1'b1) rla_cnt++;
            if (next_line_b === 1'b1) nlb_cnt++;
            if (repeat_line_b === 1'b1) rlb_cnt++;
            if (next_field_a === 1'b1) begin
                nf_prev = nf_last;
                nf_last = cyc;
                nf_cnt++;
            end
            cyc++;
            if (exp_q.size() >= 2) begin
                e_mon = exp_q.pop_front();
                n_checks++;
                if ({vga_blank_a, vga_blank_b} !== {e_mon[52], e_mon[52]}) begin
                    n_fail++;
                    $display("FAIL blank got a=%b b=%b want %b", vga_blank_a, vga_blank_b, e_mon[52]);
                end
                n_checks++;
                if ({vga_hsync_a, vga_vsync_a, vga_hsync_b, vga_vsync_b} !== e_mon[51:48]) begin
                    n_fail++;
                    $display("FAIL syncs got %b want %b",
                             {vga_hsync_a, vga_vsync_a, vga_hsync_b, vga_vsync_b}, e_mon[51:48]);
                end
                n_checks++;
                if ({vga_r_a, vga_g_a, vga_b_a} !== e_mon[47:24]) begin
                    n_fail++;
                    $display("FAIL rgb_a got %h want %h", {vga_r_a, vga_g_a, vga_b_a}, e_mon[47:24]);
                end
                n_checks++;
                if ({vga_r_b, vga_g_b, vga_b_b} !== e_mon[23:0]) begin
                    n_fail++;
                    $display("FAIL rgb_b got %h want %h", {vga_r_b, vga_g_b, vga_b_b}, e_mon[23:0]);
                end
            end
        end
    end

    // Drive one cycle, push the registered output it must produce, then advance the models
    task automatic step();
        logic [EXP_W-1:0] e;
        logic act, hw, vw;
        logic [23:0] pat, rgb_a, rgb_b;
        red_a = 8'($urandom_range(0, 255));
        green_a = 8'($urandom_range(0, 255));
        blue_a = 8'($urandom_range(0, 255));
        red_b = 8'(src_px);
        green_b = 8'(src_ly);
        blue_b = 8'hA5;
        act = (mh < 8) && (mv < 4);
        hw = (mh == 10) || (mh == 11);
        vw = (mv == 5);
        pat = {8'(mh), 8'(mv), 8'(mh ^ mv)};
        if (rst || !act) begin
            rgb_a = 24'd0;
            rgb_b = 24'd0;
        end else if (test_picture) begin
            rgb_a = pat;
            rgb_b = pat;
        end else begin
            rgb_a = {red_a, green_a, blue_a};
            rgb_b = {8'(mh / 2), 8'(mv / 2), 8'hA5};
        end
        e = {rst || !act, rst ? 1'b1 : !hw, rst ? 1'b1 : !vw,
             rst ? 1'b0 : hw, rst ? 1'b0 : vw, rgb_a, rgb_b};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            mh = 0; mv = 0; src_px = 0; src_ly = 0;
        end else begin
            if (seen_fetch_b) src_px++;
            if (seen_rl_b) src_px = 0;
            if (seen_nl_b) begin src_px = 0; src_ly++; end
            if (seen_nf_b) begin src_px = 0; src_ly = 0; end
            if (mh == 13) begin
                mh = 0;
                mv = (mv == 6) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
    endtask

    task automatic step_to(input int th, input int tv);
        for (int i = 0; i < 200 && !(mh == th && mv == tv); i++) step();
        if (!(mh == th && mv == tv)) begin
            n_fail++;
            $display("FAIL reach_position got h=%0d v=%0d want h=%0d v=%0d", mh, mv, th, tv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({vga_blank_a, vga_hsync_a, vga_vsync_a, vga_blank_b, vga_hsync_b, vga_vsync_b} !== 6'b111100) begin
            n_fail++;
            $display("FAIL reset_syncs got %b want 111100",
                     {vga_blank_a, vga_hsync_a, vga_vsync_a, vga_blank_b, vga_hsync_b, vga_vsync_b});
        end
        n_checks++;
        if ({vga_r_a, vga_g_a, vga_b_a, vga_r_b, vga_g_b, vga_b_b} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_rgb got %h want 0", {vga_r_a, vga_g_a, vga_b_a, vga_r_b, vga_g_b, vga_b_b});
        end
        n_checks++;
        if ({fetch_next_a, fetch_next_b, next_field_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pulses got %b want 000", {fetch_next_a, fetch_next_b, next_field_a});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({fetch_next_a, fetch_next_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL fetch_after_reset got %b want 10", {fetch_next_a, fetch_next_b});
        end
    endtask

    task automatic test_timing();
        int nf0;
        nf0 = nf_cnt;
        repeat (196) step();
        n_checks++;
        if (nf_cnt - nf0 != 2) begin
            n_fail++;
            $display("FAIL next_field_count got %0d want 2", nf_cnt - nf0);
        end
        n_checks++;
        if (nf_last - nf_prev != 98) begin
            n_fail++;
            $display("FAIL next_field_period got %0d want 98", nf_last - nf_prev);
        end
    endtask

    task automatic test_scaling();
        int fa0, fb0, nla0, rla0, nlb0, rlb0;
        step_to(0, 0);
        fa0 = fa_cnt; fb0 = fb_cnt; nla0 = nla_cnt; rla0 = rla_cnt; nlb0 = nlb_cnt; rlb0 = rlb_cnt;
        repeat (98) step();
        n_checks++;
        if (fa_cnt - fa0 != 32 || fb_cnt - fb0 != 16) begin
            n_fail++;
            $display("FAIL fetch_count got a=%0d b=%0d want a=32 b=16", fa_cnt - fa0, fb_cnt - fb0);
        end
        n_checks++;
        if (nla_cnt - nla0 != 3 || rla_cnt - rla0 != 0) begin
            n_fail++;
            $display("FAIL line_pulses_a got next=%0d repeat=%0d want 3 0", nla_cnt - nla0, rla_cnt - rla0);
        end
        n_checks++;
        if (nlb_cnt - nlb0 != 1 || rlb_cnt - rlb0 != 2) begin
            n_fail++;
            $display("FAIL line_pulses_b got next=%0d repeat=%0d want 1 2", nlb_cnt - nlb0, rlb_cnt - rlb0);
        end
    endtask

    task automatic test_pattern();
        step_to(5, 2);
        test_picture = 1'b1;
        step();
        test_picture = 1'b0;
        n_checks++;
        if ({vga_r_a, vga_g_a, vga_b_a} !== {8'd5, 8'd2, 8'd7}) begin
            n_fail++;
            $display("FAIL pattern_a got %h want 050207", {vga_r_a, vga_g_a, vga_b_a});
        end
        n_checks++;
        if ({vga_r_b, vga_g_b, vga_b_b} !== {8'd5, 8'd2, 8'd7}) begin
            n_fail++;
            $display("FAIL pattern_b got %h want 050207", {vga_r_b, vga_g_b, vga_b_b});
        end
        repeat (120) begin
            test_picture = 1'($urandom_range(0, 1));
            step();
        end
        test_picture = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int nf0, n;
        step_to(6, 2);
        nf0 = nf_cnt;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({vga_blank_a, vga_hsync_a, vga_vsync_a, vga_hsync_b, vga_vsync_b,
                 vga_r_a, vga_g_b} !== {5'b11100, 16'd0}) begin
                n_fail++;
                $display("FAIL mid_reset_outputs cycle %0d got blank=%b hs=%b%b vs=%b%b r=%h g=%h", i,
                         vga_blank_a, vga_hsync_a, vga_hsync_b, vga_vsync_a, vga_vsync_b, vga_r_a, vga_g_b);
            end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({hcount_a, vcount_a, fetch_next_a} !== {CNT_W'(0), CNT_W'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL restart got h=%0d v=%0d fetch=%b want 0 0 1", hcount_a, vcount_a, fetch_next_a);
        end
        n = 0;
        while (nf_cnt == nf0 && n < 150) begin
            step();
            n++;
        end
        n_checks++;
        if (n != 98) begin
            n_fail++;
            $display("FAIL first_field_after_reset got %0d cycles want 98", n);
        end
    endtask

    task automatic test_polarity();
        step_to(11, 0);
        step();
        n_checks++;
        if ({vga_hsync_a, vga_hsync_b} !== 2'b01) begin
            n_fail++;
            $display("FAIL hsync_in_window got %b want 01", {vga_hsync_a, vga_hsync_b});
        end
        step();
        n_checks++;
        if ({vga_hsync_a, vga_hsync_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL hsync_after_window got %b want 10", {vga_hsync_a, vga_hsync_b});
        end
        step_to(0, 5);
        step();
        n_checks++;
        if ({vga_vsync_a, vga_vsync_b} !== 2'b01) begin
            n_fail++;
            $display("FAIL vsync_in_window got %b want 01", {vga_vsync_a, vga_vsync_b});
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        test_reset();
        test_timing();
        test_scaling();
        test_pattern();
        test_reset_mid_frame();
        test_polarity();
        repeat (3) step();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
